// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between fetch and load/store ports
// Ports: clk/rstn (async active-low); if_* instruction read port (req/addr in, gnt/rvalid/rdata out);
// d_* load/store port (req/addr/we/wdata in, gnt/rvalid/rdata out); mem_* memory macro interface;
// busy high while an access is in flight.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH/8-1:0] d_we,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    // sel/last: 1 = data port, 0 = instruction port
    logic                  sel_q, sel_d;
    logic                  last_q, last_d;
    logic                  if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic                  if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic                  mem_en_q, mem_en_d, busy_q, busy_d;
    logic [BE_W-1:0]       mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    // The ISSUE-cycle controls are computed on the IDLE->ISSUE transition so they
    // appear registered during ISSUE; mem_addr/mem_wdata double as the latched request.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        last_d      = last_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: if (if_req || d_req) begin
                // on a tie, serve the port that was not granted last
                sel_d       = d_req && (!if_req || !last_q);
                state_d     = S_ISSUE;
                if_gnt_d    = !sel_d;
                d_gnt_d     = sel_d;
                mem_en_d    = 1'b1;
                mem_addr_d  = sel_d ? d_addr : if_addr;
                mem_we_d    = sel_d ? d_we : '0;
                mem_wdata_d = sel_d ? d_wdata : '0;
            end
            S_ISSUE: begin
                last_d  = sel_q;
                cnt_d   = CNT_INIT;
                state_d = (MEM_LATENCY == 1) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                cnt_d   = cnt_q - 3'd1;
                state_d = (cnt_q == 3'd1) ? S_RESP : S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
        if_rvalid_d = (state_d == S_RESP) && !sel_q;
        d_rvalid_d  = (state_d == S_RESP) && sel_q;
        busy_d      = state_d != S_IDLE;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end
    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port unified memory between the instruction-fetch port and the load/store port of the multicycle RV32 core. It sits between the control unit's imem/dmem strobes and the memory macro. It serializes accesses, issues each to the memory with registered controls, and returns read data or a write acknowledge after a fixed memory latency. Ties are broken round-robin so neither port starves.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8 (4 at default)
- MEM_LATENCY, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..4

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- if_req  in  1  instruction read request; level, held until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  one-cycle grant pulse for the instruction port
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_WIDTH  fetch data (driven from mem_rdata)
- d_req  in  1  data request; level, held until d_gnt
- d_addr  in  ADDR_WIDTH  data address
- d_we  in  DATA_WIDTH/8  byte write enables; 0 = read, nonzero = write
- d_wdata  in  DATA_WIDTH  store data
- d_gnt  out  1  one-cycle grant pulse for the data port
- d_rvalid  out  1  one-cycle pulse; read data valid, or write acknowledge
- d_rdata  out  DATA_WIDTH  load data (driven from mem_rdata)
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  DATA_WIDTH/8  byte write enables to the memory
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP. The 2-bit state resets to IDLE.
- IDLE: samples if_req and d_req.
  - No request: stay in IDLE.
  - One request: select that port.
  - Both: select the port that is not last_grant.
  - On selection, latch addr, we and wdata. Instruction port: we is forced to 0 and wdata to 0. Go to ISSUE.
- ISSUE (1 cycle): the selected port's gnt = 1, mem_en = 1, and mem_addr/mem_we/mem_wdata come from the latched values. Update last_grant. Load the counter with MEM_LATENCY-1.
  - MEM_LATENCY = 1: go to RESP.
  - Otherwise: go to WAIT.
- WAIT: decrement the counter each cycle; go to RESP in the cycle the counter reaches 0. WAIT therefore lasts MEM_LATENCY-1 cycles.
- RESP (1 cycle): the selected port's rvalid = 1; the other port's rvalid stays 0. Then go to IDLE.
  - A write also produces the d_rvalid pulse; d_rdata is don't-care for writes.
- if_rdata and d_rdata are both wired to mem_rdata at all times; they are meaningful only while the matching rvalid is high.
- Requests are ignored outside IDLE. A requester that keeps req high is served at a later IDLE.
- Requesters drop req in their gnt cycle. A req still high in the cycle after gnt is treated as a new request.
- last_grant resets to the data port, so the first tie goes to the instruction port.
- Outside ISSUE: mem_en = 0, mem_we = 0, and mem_addr/mem_wdata hold their last values.

## Timing
- Reset (asynchronous, rstn = 0): state = IDLE, every gnt/rvalid = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, busy = 0, counter = 0, last_grant = data.
- Reset mid-transaction: any in-flight access is dropped and no rvalid is produced after reset is released.
- All outputs come from registers, except rdata, which is a wire from mem_rdata.
- A request is seen in IDLE at cycle N. Then:
  - gnt and mem_en at cycle N+1
  - rvalid at cycle N+1+MEM_LATENCY
  - back in IDLE at N+2+MEM_LATENCY
- Minimum spacing between grants is MEM_LATENCY+2 cycles.
- A request arriving during RESP is sampled in the following IDLE cycle. There is no IDLE bypass.
- busy = 1 from ISSUE through RESP inclusive.

## Test plan
- MEM_LATENCY=2. if_req at cycle 0 with if_addr=0x100, and the memory model returns 0xDEADBEEF. Required:
  - if_gnt and mem_en at cycle 1, with mem_addr=0x100 and mem_we=0
  - if_rvalid at cycle 3 with if_rdata=0xDEADBEEF
  - busy high in cycles 1–3
- if_req and d_req asserted together at cycle 0 right after reset and both held. Required:
  - if_gnt at cycle 1
  - d_gnt at cycle 5 (MEM_LATENCY=2)
  - a second simultaneous pair is then granted to the instruction port (it is not last_grant)
- Store with d_we=4'b0011, d_addr=0x2004, d_wdata=0x0000ABCD. Required:
  - mem_we=4'b0011, mem_wdata=0x0000ABCD and mem_addr=0x2004 in the ISSUE cycle only
  - d_rvalid pulse at MEM_LATENCY cycles after ISSUE
  - if_rvalid stays 0
- d_req raised during WAIT of an instruction access and held. Required: no d_gnt until the IDLE following RESP; d_gnt exactly 1 cycle after that IDLE.
- rstn pulsed low during WAIT. Required:
  - all outputs 0 immediately
  - no rvalid after release
  - a new if_req is granted 1 cycle after being sampled in IDLE
- Sweep MEM_LATENCY=1 and MEM_LATENCY=4 with a single read. Required: rvalid exactly 1 cycle and 4 cycles after mem_en respectively.
